// File: rtl/ram_access_arbiter.sv
// ram_access_arbiter
//   Round-robin arbiter sharing one single-port RAM (async read, write on
//   cs & we) between two requesters. The winning command is registered,
//   driven onto the RAM for exactly one cycle, and read data is returned
//   through a registered rdata with a one-cycle rvalid pulse.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   req0/we0/addr0/wdata0   requester 0 command, held until gnt0
//   gnt0, rvalid0           requester 0 grant / read-valid pulses
//   req1/we1/addr1/wdata1   requester 1 command, held until gnt1
//   gnt1, rvalid1           requester 1 grant / read-valid pulses
//   rdata                   shared read data, qualified by rvalid0/rvalid1
//   busy                    high while an access is in flight
//   mem_cs/mem_we/mem_addr/mem_wdata   RAM command (all registered)
//   mem_rdata               RAM combinational read data
//
// State table
//   state  | meaning
//   IDLE   | sampling requests; RAM deselected
//   ACCESS | RAM selected for the granted command; read data captured at exit
module ram_access_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              rvalid0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              mem_cs,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic                last_owner_q, last_owner_d;
    logic                owner_q, owner_d;
    logic                owner_rd_q, owner_rd_d;
    logic                gnt0_q, gnt0_d;
    logic                gnt1_q, gnt1_d;
    logic                rvalid0_q, rvalid0_d;
    logic                rvalid1_q, rvalid1_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                busy_q, busy_d;
    logic                mem_cs_q, mem_cs_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

    logic                win;
    logic                we_sel;
    logic [ADDR_W-1:0]   addr_sel;
    logic [DATA_W-1:0]   wdata_sel;

    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        owner_d      = owner_q;
        owner_rd_d   = owner_rd_q;
        gnt0_d       = 1'b0;
        gnt1_d       = 1'b0;
        rvalid0_d    = 1'b0;
        rvalid1_d    = 1'b0;
        rdata_d      = rdata_q;
        busy_d       = 1'b0;
        mem_cs_d     = 1'b0;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;

        // Under contention the side that did not win last time goes next.
        win = (req0 && req1) ? ~last_owner_q : req1;

        // Explicit branches so an idle requester's X payload never leaks
        // into the RAM command when the other side wins.
        if (win) begin
            we_sel    = we1;
            addr_sel  = addr1;
            wdata_sel = wdata1;
        end else begin
            we_sel    = we0;
            addr_sel  = addr0;
            wdata_sel = wdata0;
        end

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    mem_cs_d     = 1'b1;
                    mem_we_d     = we_sel;
                    mem_addr_d   = addr_sel;
                    mem_wdata_d  = wdata_sel;
                    busy_d       = 1'b1;
                    gnt0_d       = ~win;
                    gnt1_d       = win;
                    last_owner_d = win;
                    owner_d      = win;
                    owner_rd_d   = ~we_sel;
                    state_d      = ACCESS;
                end
            end
            ACCESS: begin
                if (owner_rd_q) begin
                    rdata_d   = mem_rdata;
                    rvalid0_d = ~owner_q;
                    rvalid1_d = owner_q;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_owner_q <= 1'b1;
            owner_q      <= 1'b0;
            owner_rd_q   <= 1'b0;
            gnt0_q       <= 1'b0;
            gnt1_q       <= 1'b0;
            rvalid0_q    <= 1'b0;
            rvalid1_q    <= 1'b0;
            rdata_q      <= '0;
            busy_q       <= 1'b0;
            mem_cs_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            owner_q      <= owner_d;
            owner_rd_q   <= owner_rd_d;
            gnt0_q       <= gnt0_d;
            gnt1_q       <= gnt1_d;
            rvalid0_q    <= rvalid0_d;
            rvalid1_q    <= rvalid1_d;
            rdata_q      <= rdata_d;
            busy_q       <= busy_d;
            mem_cs_q     <= mem_cs_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign gnt0      = gnt0_q;
    assign gnt1      = gnt1_q;
    assign rvalid0   = rvalid0_q;
    assign rvalid1   = rvalid1_q;
    assign rdata     = rdata_q;
    assign busy      = busy_q;
    assign mem_cs    = mem_cs_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Testbench for ram_access_arbiter: a RAM macro model on the memory port,
// two queue-driven requesters, and a transaction-level reference model
// (expected memory contents, round-robin winner, grant/rvalid timing).
module tb_ram_access_arbiter;

    localparam int AW    = 10;
    localparam int DW    = 8;
    localparam int DEPTH = 1 << AW;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } op_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0, we0, req1, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, rvalid0, rvalid1, busy;
    logic [DW-1:0] rdata;
    logic          mem_cs, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    ram_access_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .rvalid0(rvalid0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .rvalid1(rvalid1),
        .rdata(rdata), .busy(busy),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // RAM macro: async read, write on cs & we at the rising edge.
    logic [DW-1:0] ram [DEPTH];
    always @(posedge clk) if (mem_cs && mem_we) ram[mem_addr] <= mem_wdata;
    assign mem_rdata = ram[mem_addr];

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [DW-1:0] exp_mem [DEPTH];
    int            m_last;
    bit            m_free;
    bit            m_pend_rd;
    int            m_owner;
    logic [DW-1:0] m_pend_data;
    logic [DW-1:0] m_rdata;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;

    op_t q0[$];
    op_t q1[$];

    function automatic op_t mk(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        op_t o;
        o.we = we; o.addr = a; o.wdata = d;
        return o;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_last = 1; m_free = 1; m_pend_rd = 0; m_owner = 0;
        m_rdata = '0; m_addr = '0; m_wdata = '0; m_pend_data = '0;
    endtask

    task automatic idle_inputs();
        req0 = 1'b0; we0 = 1'bx; addr0 = 'x; wdata0 = 'x;
        req1 = 1'b0; we1 = 1'bx; addr1 = 'x; wdata1 = 'x;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt0"},    32'(gnt0),      0);
        chk({tag, "_gnt1"},    32'(gnt1),      0);
        chk({tag, "_rvalid0"}, 32'(rvalid0),   0);
        chk({tag, "_rvalid1"}, 32'(rvalid1),   0);
        chk({tag, "_busy"},    32'(busy),      0);
        chk({tag, "_mem_cs"},  32'(mem_cs),    0);
        chk({tag, "_mem_we"},  32'(mem_we),    0);
        chk({tag, "_addr"},    32'(mem_addr),  0);
        chk({tag, "_wdata"},   32'(mem_wdata), 0);
        chk({tag, "_rdata"},   32'(rdata),     0);
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        #1;
        chk_all_zero("reset");
        step();
        rst_n = 1'b1;
        model_reset();
    endtask

    // Drives queued commands and checks every cycle against the model.
    // rnd=1 randomly delays when a requester first raises req.
    task automatic run(input string name, input bit rnd, input int max_cyc);
        bit act0, act1, pop0, pop1, g0, g1, done;
        bit e_g0, e_g1, e_rv0, e_rv1, e_busy, e_cs, e_we;
        op_t h0, h1, h;
        int w, cyc;
        act0 = 0; act1 = 0; pop0 = 0; pop1 = 0; cyc = 0;
        h0 = '0; h1 = '0;
        done = (q0.size() == 0 && q1.size() == 0 && m_free);
        while (!done && cyc < max_cyc) begin
            if (!act0 && q0.size() > 0 && (!rnd || $urandom_range(1, 0) == 1)) act0 = 1;
            if (!act1 && q1.size() > 0 && (!rnd || $urandom_range(1, 0) == 1)) act1 = 1;
            if (act0) begin
                h0 = q0[0];
                req0 = 1'b1; we0 = h0.we; addr0 = h0.addr; wdata0 = h0.wdata;
            end else begin
                req0 = 1'b0; we0 = 1'bx; addr0 = 'x; wdata0 = 'x;
            end
            if (act1) begin
                h1 = q1[0];
                req1 = 1'b1; we1 = h1.we; addr1 = h1.addr; wdata1 = h1.wdata;
            end else begin
                req1 = 1'b0; we1 = 1'bx; addr1 = 'x; wdata1 = 'x;
            end

            e_g0 = 0; e_g1 = 0; e_rv0 = 0; e_rv1 = 0; e_busy = 0; e_cs = 0; e_we = 0;
            g0 = 0; g1 = 0;
            if (!m_free) begin
                if (m_pend_rd) begin
                    if (m_owner == 0) e_rv0 = 1; else e_rv1 = 1;
                    m_rdata = m_pend_data;
                end
                m_pend_rd = 0;
                m_free = 1;
            end else if ((act0 && !pop0) || (act1 && !pop1)) begin
                if (act0 && act1) w = 1 - m_last;
                else w = act1 ? 1 : 0;
                h = (w == 1) ? h1 : h0;
                if (w == 1) begin e_g1 = 1; g1 = 1; end
                else begin e_g0 = 1; g0 = 1; end
                e_busy = 1; e_cs = 1; e_we = h.we;
                m_addr = h.addr; m_wdata = h.wdata;
                m_last = w; m_owner = w;
                if (h.we) exp_mem[h.addr] = h.wdata;
                else begin m_pend_rd = 1; m_pend_data = exp_mem[h.addr]; end
                m_free = 0;
            end

            step();
            cyc++;

            // A granted command is withdrawn only after its gnt cycle ends.
            if (pop0) begin void'(q0.pop_front()); act0 = 0; pop0 = 0; end
            if (pop1) begin void'(q1.pop_front()); act1 = 0; pop1 = 0; end
            if (g0) pop0 = 1;
            if (g1) pop1 = 1;

            chk({name, "_gnt0"},    32'(gnt0),      32'(e_g0));
            chk({name, "_gnt1"},    32'(gnt1),      32'(e_g1));
            chk({name, "_busy"},    32'(busy),      32'(e_busy));
            chk({name, "_mem_cs"},  32'(mem_cs),    32'(e_cs));
            chk({name, "_mem_we"},  32'(mem_we),    32'(e_we));
            chk({name, "_mem_addr"},32'(mem_addr),  32'(m_addr));
            chk({name, "_mem_wdata"},32'(mem_wdata),32'(m_wdata));
            chk({name, "_rvalid0"}, 32'(rvalid0),   32'(e_rv0));
            chk({name, "_rvalid1"}, 32'(rvalid1),   32'(e_rv1));
            chk({name, "_rdata"},   32'(rdata),     32'(m_rdata));

            done = (q0.size() == 0 && q1.size() == 0 && m_free && !pop0 && !pop1);
        end
        chk({name, "_completed"}, 32'(done), 1);
        q0.delete();
        q1.delete();
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            ram[i]     = 8'($urandom);
            exp_mem[i] = ram[i];
        end
        model_reset();
        #3;
        chk_all_zero("por");
        step();
        rst_n = 1'b1;

        // 1: write then read, requester 0
        q0.push_back(mk(1'b1, 10'd5, 8'hA5));
        run("t1_wr", 0, 20);
        chk("t1_ram5", 32'(ram[5]), 32'h00A5);
        q0.push_back(mk(1'b0, 10'd5, 8'h3C));
        run("t1_rd", 0, 20);
        chk("t1_rdata", 32'(rdata), 32'h00A5);

        // 2: contention straight from reset
        do_reset();
        ram[10] = 8'h14; exp_mem[10] = 8'h14;
        ram[20] = 8'h28; exp_mem[20] = 8'h28;
        q0.push_back(mk(1'b0, 10'd10, 8'h00));
        q1.push_back(mk(1'b0, 10'd20, 8'h00));
        run("t2", 0, 20);
        chk("t2_rdata_last", 32'(rdata), 32'h0028);

        // 3: continuous contention, writes of k*2 to addr k, then read back
        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 0) q0.push_back(mk(1'b1, AW'(k), DW'(k * 2)));
            else            q1.push_back(mk(1'b1, AW'(k), DW'(k * 2)));
        end
        run("t3_wr", 0, 40);
        for (int k = 0; k < 8; k++) q0.push_back(mk(1'b0, AW'(k), 8'h00));
        run("t3_rd", 0, 40);

        // 4: boundary addresses
        q0.push_back(mk(1'b1, 10'd1023, 8'hFF));
        q1.push_back(mk(1'b1, 10'd0, 8'h01));
        run("t4_wr", 0, 20);
        q1.push_back(mk(1'b0, 10'd1023, 8'h00));
        run("t4_rd_hi", 0, 20);
        chk("t4_rdata_hi", 32'(rdata), 32'h00FF);
        q0.push_back(mk(1'b0, 10'd0, 8'h00));
        run("t4_rd_lo", 0, 20);
        chk("t4_rdata_lo", 32'(rdata), 32'h0001);

        // 5: reset in the middle of an access
        req1 = 1'b1; we1 = 1'b0; addr1 = 10'd7; wdata1 = 8'h00;
        step();
        chk("t5_gnt1_pre", 32'(gnt1), 1);
        chk("t5_busy_pre", 32'(busy), 1);
        chk("t5_cs_pre",   32'(mem_cs), 1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("t5_rst");
        idle_inputs();
        step();
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            step();
            chk("t5_no_rvalid0", 32'(rvalid0), 0);
            chk("t5_no_rvalid1", 32'(rvalid1), 0);
            chk("t5_no_busy",    32'(busy), 0);
        end
        q0.push_back(mk(1'b0, 10'd3, 8'h00));
        q1.push_back(mk(1'b0, 10'd4, 8'h00));
        run("t5_post", 0, 20);

        // 6: single requester back-to-back reads
        q1.push_back(mk(1'b0, 10'd1, 8'h00));
        q1.push_back(mk(1'b0, 10'd1023, 8'h00));
        q1.push_back(mk(1'b0, 10'd6, 8'h00));
        run("t6", 0, 20);

        // Randomized mix of reads/writes with random request timing
        for (int i = 0; i < 40; i++) begin
            q0.push_back(mk(1'($urandom), AW'($urandom), DW'($urandom)));
            q1.push_back(mk(1'($urandom), AW'($urandom_range(15, 0)), DW'($urandom)));
        end
        run("rnd", 1, 2000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
